// File: rtl/bsg_chip_reset_sequencer.sv
// bsg_chip_reset_sequencer: holds router and core resets for a minimum time, then releases router before core.
// Optional feature: define BSG_RESET_SEQ_DID_LOCK_EN to freeze the destination ID while the core is running.
module bsg_chip_reset_sequencer #(
    parameter int did_width_p      = 8,
    parameter int hold_cycles_p    = 16,
    parameter int stagger_cycles_p = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   tag_new_i,
    input  logic                   tag_reset_i,
    input  logic [did_width_p-1:0] tag_did_i,
    output logic                   router_reset_o,
    output logic                   core_reset_o,
    output logic [did_width_p-1:0] did_o,
    output logic                   ready_o
);

    localparam int max_cycles_lp = (hold_cycles_p > stagger_cycles_p) ? hold_cycles_p : stagger_cycles_p;
    localparam int cnt_width_lp  = $clog2(max_cycles_lp + 1);
    localparam logic [cnt_width_lp-1:0] hold_last_lp    = cnt_width_lp'(hold_cycles_p - 1);
    localparam logic [cnt_width_lp-1:0] stagger_last_lp = cnt_width_lp'(stagger_cycles_p - 1);

    typedef enum logic [1:0] {HOLD, STAGGER, RUN} state_e;

    state_e                  state, state_n;
    logic [cnt_width_lp-1:0] cnt, cnt_n;
    logic                    req_r, req_n, did_load;
    logic [did_width_p-1:0]  did_r;

    // A strobe acts in the cycle it arrives; otherwise the last request persists.
    assign req_n = tag_new_i ? tag_reset_i : req_r;

`ifdef BSG_RESET_SEQ_DID_LOCK_EN
    // Once the core runs, the ID only changes together with a reset request.
    assign did_load = tag_new_i && (state != RUN || tag_reset_i);
`else
    assign did_load = tag_new_i;
`endif

    // State, counter, latched request and destination ID registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= HOLD;
            cnt   <= '0;
            req_r <= 1'b1;
            did_r <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            req_r <= req_n;
            if (did_load) did_r <= tag_did_i;
        end
    end

    // Next state: re-assertion always wins and restarts a full hold.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            HOLD: begin
                if (cnt == hold_last_lp && !req_n) begin
                    state_n = STAGGER;
                    cnt_n   = '0;
                end else if (cnt != hold_last_lp) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STAGGER: begin
                if (req_n) begin
                    state_n = HOLD;
                    cnt_n   = '0;
                end else if (cnt == stagger_last_lp) begin
                    state_n = RUN;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RUN: begin
                if (req_n) begin
                    state_n = HOLD;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = HOLD;
                cnt_n   = '0;
            end
        endcase
    end

    assign router_reset_o = (state == HOLD);
    assign core_reset_o   = (state != RUN);
    assign ready_o        = (state == RUN);
    assign did_o          = did_r;

endmodule

// File: tb/tb_bsg_chip_reset_sequencer.sv
// tb_bsg_chip_reset_sequencer: directed bench for the reset sequencer (hold 4/stagger 3, plus a 1/1 boundary instance).
module tb_bsg_chip_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tag_new = 1'b0;
    logic       tag_reset = 1'b0;
    logic [7:0] tag_did = 8'h00;
    logic       router_reset, core_reset, ready;
    logic [7:0] did;
    logic       b_router_reset, b_core_reset, b_ready;
    logic [7:0] b_did;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        string      tag;
        logic       r, c, y;
        logic [7:0] d;
        logic       bchk, br, bc;
    } exp_t;

    exp_t sb[$];

`ifdef BSG_RESET_SEQ_DID_LOCK_EN
    localparam logic [7:0] locked_did = 8'h12;
`else
    localparam logic [7:0] locked_did = 8'h34;
`endif

    always #5 clk = ~clk;

    bsg_chip_reset_sequencer #(.did_width_p(8), .hold_cycles_p(4), .stagger_cycles_p(3)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .tag_new_i(tag_new), .tag_reset_i(tag_reset),
        .tag_did_i(tag_did), .router_reset_o(router_reset), .core_reset_o(core_reset),
        .did_o(did), .ready_o(ready)
    );

    bsg_chip_reset_sequencer #(.did_width_p(8), .hold_cycles_p(1), .stagger_cycles_p(1)) dut_b (
        .clk_i(clk), .reset_n_i(reset_n), .tag_new_i(tag_new), .tag_reset_i(tag_reset),
        .tag_did_i(tag_did), .router_reset_o(b_router_reset), .core_reset_o(b_core_reset),
        .did_o(b_did), .ready_o(b_ready)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_head();
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, ".router"}, {7'd0, router_reset}, {7'd0, e.r});
        chk({e.tag, ".core"},   {7'd0, core_reset},   {7'd0, e.c});
        chk({e.tag, ".ready"},  {7'd0, ready},        {7'd0, e.y});
        chk({e.tag, ".did"},    did,                  e.d);
        if (e.bchk) begin
            chk({e.tag, ".b_router"}, {7'd0, b_router_reset}, {7'd0, e.br});
            chk({e.tag, ".b_core"},   {7'd0, b_core_reset},   {7'd0, e.bc});
            chk({e.tag, ".b_ready"},  {7'd0, b_ready},        {7'd0, ~e.bc});
        end
    endtask

    // Drive one cycle of stimulus, queue what the outputs must be after the edge, then check.
    task automatic tick(input logic nw, input logic rs, input logic [7:0] d, input string tag,
                        input logic er, input logic ec, input logic ey, input logic [7:0] ed,
                        input logic bchk, input logic br, input logic bc);
        sb.push_back('{tag, er, ec, ey, ed, bchk, br, bc});
        tag_new = nw;
        tag_reset = rs;
        tag_did = d;
        @(posedge clk);
        #1;
        tag_new = 1'b0;
        compare_head();
    endtask

    task automatic now(input string tag, input logic er, input logic ec, input logic ey,
                       input logic [7:0] ed, input logic bchk, input logic br, input logic bc);
        sb.push_back('{tag, er, ec, ey, ed, bchk, br, bc});
        compare_head();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        now("por_low", 1, 1, 0, 8'h00, 1, 1, 1);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        now("por_rel", 1, 1, 0, 8'h00, 1, 1, 1);
        tick(1, 0, 8'h12, "por_c1", 1, 1, 0, 8'h12, 1, 0, 1);
        tick(0, 0, 8'h00, "por_c2", 1, 1, 0, 8'h12, 1, 0, 0);
        tick(0, 0, 8'h00, "por_c3", 1, 1, 0, 8'h12, 1, 0, 0);
        tick(0, 0, 8'h00, "por_c4", 0, 1, 0, 8'h12, 1, 0, 0);
        tick(0, 0, 8'h00, "por_c5", 0, 1, 0, 8'h12, 1, 0, 0);
        tick(0, 0, 8'h00, "por_c6", 0, 1, 0, 8'h12, 1, 0, 0);
        tick(0, 0, 8'h00, "por_c7", 0, 0, 1, 8'h12, 1, 0, 0);
        tick(0, 0, 8'h00, "por_c8", 0, 0, 1, 8'h12, 1, 0, 0);

        tick(1, 1, 8'h12, "ras_c1", 1, 1, 0, 8'h12, 1, 1, 1);
        tick(1, 0, 8'h12, "ras_c2", 1, 1, 0, 8'h12, 1, 0, 1);
        tick(0, 0, 8'h00, "ras_c3", 1, 1, 0, 8'h12, 1, 0, 0);
        tick(0, 0, 8'h00, "ras_c4", 1, 1, 0, 8'h12, 1, 0, 0);
        tick(0, 0, 8'h00, "ras_c5", 0, 1, 0, 8'h12, 1, 0, 0);
        tick(0, 0, 8'h00, "ras_c6", 0, 1, 0, 8'h12, 1, 0, 0);
        tick(0, 0, 8'h00, "ras_c7", 0, 1, 0, 8'h12, 1, 0, 0);
        tick(0, 0, 8'h00, "ras_c8", 0, 0, 1, 8'h12, 1, 0, 0);

        tick(1, 1, 8'h12, "exp_c1", 1, 1, 0, 8'h12, 0, 0, 0);
        tick(1, 0, 8'h12, "exp_c2", 1, 1, 0, 8'h12, 0, 0, 0);
        tick(0, 0, 8'h00, "exp_c3", 1, 1, 0, 8'h12, 0, 0, 0);
        tick(0, 0, 8'h00, "exp_c4", 1, 1, 0, 8'h12, 0, 0, 0);
        tick(0, 0, 8'h00, "exp_c5", 0, 1, 0, 8'h12, 0, 0, 0);
        tick(0, 0, 8'h00, "exp_c6", 0, 1, 0, 8'h12, 0, 0, 0);
        tick(0, 0, 8'h00, "exp_c7", 0, 1, 0, 8'h12, 0, 0, 0);
        tick(1, 1, 8'h12, "exp_c8", 1, 1, 0, 8'h12, 0, 0, 0);
        tick(0, 0, 8'h00, "exp_c9", 1, 1, 0, 8'h12, 0, 0, 0);
        tick(1, 0, 8'h12, "exp_r1", 1, 1, 0, 8'h12, 0, 0, 0);
        tick(0, 0, 8'h00, "exp_r2", 1, 1, 0, 8'h12, 0, 0, 0);
        tick(0, 0, 8'h00, "exp_r3", 0, 1, 0, 8'h12, 0, 0, 0);
        tick(0, 0, 8'h00, "exp_r4", 0, 1, 0, 8'h12, 0, 0, 0);
        tick(0, 0, 8'h00, "exp_r5", 0, 1, 0, 8'h12, 0, 0, 0);
        tick(0, 0, 8'h00, "exp_r6", 0, 0, 1, 8'h12, 0, 0, 0);

        reset_n = 1'b0;
        #1;
        now("rstn_async", 1, 1, 0, 8'h00, 1, 1, 1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        now("rstn_rel", 1, 1, 0, 8'h00, 1, 1, 1);
        for (int i = 0; i < 6; i++) tick(0, 0, 8'h00, "rstn_idle", 1, 1, 0, 8'h00, 1, 1, 1);
        tick(1, 0, 8'h12, "rstn_c1", 0, 1, 0, 8'h12, 1, 0, 1);
        tick(0, 0, 8'h00, "rstn_c2", 0, 1, 0, 8'h12, 1, 0, 0);
        tick(0, 0, 8'h00, "rstn_c3", 0, 1, 0, 8'h12, 1, 0, 0);
        tick(0, 0, 8'h00, "rstn_c4", 0, 0, 1, 8'h12, 1, 0, 0);

        tick(1, 0, 8'h34, "lock_run", 0, 0, 1, locked_did, 1, 0, 0);
        tick(1, 1, 8'h34, "lock_rst", 1, 1, 0, 8'h34, 1, 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/bsg_chip_reset_sequencer.md
# bsg_chip_reset_sequencer

Sequences the router-domain and core-domain resets for the single-core BlackParrot chip from one bsg_tag payload stream. It sits directly downstream of a `bsg_tag_client` whose payload is `{reset, did}`, and drives the reset inputs of the routers, the link clients and `bp_processor`. It applies a guaranteed minimum reset hold and releases the router domain a fixed number of cycles before the core domain. It also registers the destination ID so that reset and ID change together.

## Interface

Parameters:

- `did_width_p`, default 8: width of the destination-ID field; matches `wh_did_width_gp`.
- `hold_cycles_p`, default 16: minimum number of cycles both resets stay asserted once asserted. Must be 1 or more.
- `stagger_cycles_p`, default 8: number of cycles between router reset release and core reset release. Must be 1 or more.

Ports:

- `clk_i` input 1: the single clock; the router clock domain. All logic is in this one clock domain.
- `reset_n_i` input 1: asynchronous, active-low reset.
- `tag_new_i` input 1: one-cycle strobe from the tag client (`recv_new_r_o`); the payload below is valid this cycle.
- `tag_reset_i` input 1: payload reset request bit; 1 requests reset.
- `tag_did_i` input `did_width_p`: payload destination ID.
- `router_reset_o` output 1: active-high reset for the router, link clients and memory domain.
- `core_reset_o` output 1: active-high reset for the `bp_processor` core and coherence domain.
- `did_o` output `did_width_p`: registered destination ID.
- `ready_o` output 1: high only in RUN, when both domains are out of reset.

## Operation

- Internal registers:
  - `state` ∈ {HOLD, STAGGER, RUN}
  - `cnt`, width `$clog2(max(hold_cycles_p, stagger_cycles_p)+1)`
  - `req_r`, the last latched request
  - `did_r`
- Effective request each cycle: `req_n = tag_new_i ? tag_reset_i : req_r`. `req_r <= req_n` every cycle. A strobe therefore takes effect in the same cycle it arrives.
- While `reset_n_i` is low:
  - `state` = HOLD, `cnt` = 0, `req_r` = 1, `did_r` = 0.
  - Outputs: `router_reset_o` = 1, `core_reset_o` = 1, `ready_o` = 0, `did_o` = 0.
- HOLD: both resets = 1.
  - `cnt` increments, saturating at `hold_cycles_p-1`.
  - Exit to STAGGER with `cnt` cleared when `cnt == hold_cycles_p-1` and `req_n == 0`.
  - Otherwise remain in HOLD.
- STAGGER: `router_reset_o` = 0, `core_reset_o` = 1.
  - If `req_n == 1`, go to HOLD with `cnt` cleared.
  - Otherwise, if `cnt == stagger_cycles_p-1`, go to RUN.
  - Otherwise increment `cnt`.
- RUN: both resets = 0, `ready_o` = 1.
  - If `req_n == 1`, go to HOLD with `cnt` cleared.
- Re-assertion in STAGGER or RUN always restarts the full `hold_cycles_p` hold. It never truncates.
- `did_r`: loads `tag_did_i` on every `tag_new_i`, unless locked (see Configuration).
- Outputs are pure functions of registered state, so the block has no combinational input-to-output path.

## Timing

- Assert latency: a `tag_new_i` strobe with `reset` = 1 sampled at edge *t* makes both resets high after edge *t*, i.e. visible in cycle *t*+1.
- Deassert sequence, counted from entry into HOLD with the request already low:
  - `router_reset_o` falls after exactly `hold_cycles_p` cycles.
  - `core_reset_o` falls `stagger_cycles_p` cycles after that.
  - `ready_o` rises in the same cycle `core_reset_o` falls.
- `did_o` changes one cycle after the strobe, in the same cycle the resets respond to that strobe.
- Simultaneous reassert and expiry: if the request goes high (`req_n` = 1) in the cycle the STAGGER counter expires, re-assertion wins and the block goes to HOLD.
- `reset_n_i` assertion mid-sequence forces the reset state immediately, asynchronously. Deassertion is expected to be synchronised externally; the block makes no internal synchroniser guarantee.
- Repeated strobes with `reset` = 1 while in HOLD do not clear `cnt`.

## Configuration

- `BSG_RESET_SEQ_DID_LOCK_EN`:
  - Defined: `did_r` loads only when `core_reset_o` is 1, or when the same strobe has `tag_reset_i` = 1. A strobe in RUN with `reset` = 0 and a new ID leaves `did_o` unchanged.
  - Undefined: `did_r` loads on every strobe, in any state.

## Test plan

Unless noted, `hold_cycles_p` = 4, `stagger_cycles_p` = 3, `did_width_p` = 8.

- Power-on: hold `reset_n_i` low 5 cycles, then release, then send a strobe `{reset=0, did=0x12}` at cycle 0 -> `router_reset_o` falls at cycle 4, `core_reset_o` falls and `ready_o` rises at cycle 7, `did_o` = 0x12 from cycle 1.
- In RUN, send a strobe `{1, 0x12}` at cycle 0 and a strobe `{0, 0x12}` at cycle 1 -> both resets high from cycle 1 to cycle 4, router released at cycle 5 (`hold_cycles_p` = 4 cycles from the cycle-1 HOLD entry), core released at cycle 8.
- In STAGGER, send a strobe `{1}` in the cycle `cnt` = 2 (counter expiry) -> state goes to HOLD, `core_reset_o` never drops, `router_reset_o` returns to 1 the next cycle.
- Pulse `reset_n_i` low for one cycle in RUN -> all outputs return to their reset values immediately, and after release the sequence completes only after a new strobe with `reset` = 0.
- With `BSG_RESET_SEQ_DID_LOCK_EN` defined, in RUN send a strobe `{0, 0x34}` -> `did_o` stays 0x12; then send a strobe `{1, 0x34}` -> `did_o` = 0x34. With the macro undefined, the first strobe alone updates `did_o` to 0x34.
- Boundary: `hold_cycles_p` = 1, `stagger_cycles_p` = 1, strobe `{0}` immediately after reset release -> router released 1 cycle after HOLD entry, core released 1 cycle later.
